// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage.
// Holds the PC, computes the sequential next PC, arbitrates exception/branch/jump
// redirects against stall and halt, and runs a RUN/HALTED state machine with
// debug resume. The FSM state is visible through o_halted, which is a direct
// decode of the single state bit.
module pc_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned EXC_VECTOR   = 'h80,
  parameter int unsigned INCR         = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_resume,
  input  logic                  i_exception,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_seq,
  output logic [DATA_WIDTH-1:0] o_epc,
  output logic                  o_fetch_en,
  output logic                  o_halted,
  output logic                  o_redirected
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VECTOR);
  localparam logic [DATA_WIDTH-1:0] EXC_PC   = DATA_WIDTH'(EXC_VECTOR);
  localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(INCR);

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] epc;
  logic [DATA_WIDTH-1:0] epc_next;
  logic                  redirected;
  logic                  redirected_next;
  logic [DATA_WIDTH-1:0] pc_seq;

  // Sequential address; wraps modulo 2^DATA_WIDTH by construction.
  always_comb begin
    pc_seq = pc + STEP;
  end

  // Next-state arbitration: in RUN the first matching request wins
  // (halt, exception, stall, branch, jump, sequential). HALTED ignores
  // everything except resume, and a simultaneous halt keeps it halted.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    epc_next        = epc;
    redirected_next = 1'b0;
    if (state == RUN) begin
      if (i_halt) begin
        state_next = HALTED;
      end else if (i_exception) begin
        pc_next         = EXC_PC;
        epc_next        = pc;
        redirected_next = 1'b1;
      end else if (i_stall) begin
        pc_next = pc;
      end else if (i_branch_taken) begin
        pc_next         = i_branch_target;
        redirected_next = 1'b1;
      end else if (i_jump) begin
        pc_next         = i_jump_target;
        redirected_next = 1'b1;
      end else begin
        pc_next = pc_seq;
      end
    end else begin
      if (i_resume && !i_halt) begin
        state_next = RUN;
      end
    end
  end

  // Register update; synchronous reset overrides every request.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      epc        <= '0;
      redirected <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      epc        <= epc_next;
      redirected <= redirected_next;
    end
  end

  // Output decode; a fetch is issued only while running and not bubbled.
  always_comb begin
    o_pc         = pc;
    o_pc_seq     = pc_seq;
    o_epc        = epc;
    o_redirected = redirected;
    o_halted     = (state == HALTED);
    o_fetch_en   = (state == RUN) && !i_stall && !i_reset;
  end

endmodule
